// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory port arbiter.
package mem_arbiter_pkg;
  localparam int NUM_MASTERS = 2;

  typedef enum logic {MST_INSTR = 1'b0, MST_DATA = 1'b1} mst_id_e;
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;
endpackage

// File: rtl/mem_arbiter_resp_id_fifo.sv
// In-order queue of master IDs for accepted-but-unanswered transactions.
module resp_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] ids;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = ids[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and load/store.
// MEM_ARBITER_ROUND_ROBIN_EN selects round-robin instead of data-over-instr priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_req_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic [DATA_W-1:0]   instr_rdata_o,
  input  logic                data_req_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  lock_state_e state_q, state_d;
  mst_id_e     lock_mst_q, lock_mst_d;
  mst_id_e     winner, sel, head;
  logic        sel_req, req_ok, push, route_ok;
  logic        q_full, q_empty, q_head;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  mst_id_e rr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     rr_q <= MST_DATA;
    else if (push) rr_q <= (sel == MST_DATA) ? MST_INSTR : MST_DATA;
  end

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    winner = rr_q;
    if (data_req_i && !instr_req_i)      winner = MST_DATA;
    else if (instr_req_i && !data_req_i) winner = MST_INSTR;
  end
`else
  assign winner = data_req_i ? MST_DATA : MST_INSTR;
`endif

  assign sel     = (state_q == LOCKED) ? lock_mst_q : winner;
  assign sel_req = (sel == MST_DATA) ? data_req_i : instr_req_i;
  // Full flag comes from the registered count, so a same-cycle pop cannot unblock.
  assign req_ok  = sel_req & ~q_full & ~rst_i;
  assign push    = req_ok & mem_gnt_i;

  assign mem_req_o   = req_ok;
  assign instr_gnt_o = push & (sel == MST_INSTR);
  assign data_gnt_o  = push & (sel == MST_DATA);

  assign head           = mst_id_e'(q_head);
  assign route_ok       = mem_rvalid_i & ~q_empty & ~rst_i;
  assign instr_rvalid_o = route_ok & (head == MST_INSTR);
  assign data_rvalid_o  = route_ok & (head == MST_DATA);
  assign instr_rdata_o  = rst_i ? '0 : mem_rdata_i;
  assign data_rdata_o   = rst_i ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= UNLOCKED;
      lock_mst_q <= MST_INSTR;
    end else begin
      state_q    <= state_d;
      lock_mst_q <= lock_mst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_mst_d  = lock_mst_q;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      UNLOCKED: if (req_ok && !mem_gnt_i) begin
        state_d    = LOCKED;
        lock_mst_d = sel;
      end
      LOCKED:   if (mem_gnt_i) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
    if (!rst_i) begin
      if (sel == MST_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = '1;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  resp_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_resp_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .push_id (sel),
    .pop     (mem_rvalid_i & ~rst_i),
    .full    (q_full),
    .empty   (q_empty),
    .head    (q_head)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(mem_rvalid_i && q_empty))
      else $warning("mem_rvalid_i with no outstanding transaction, response dropped");
  end
`endif
endmodule
